// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared codes and constants for the DDS phase generator
package dds_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_DC     = 2'd3
    } waveSel_t;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_RUN    = 2'd1,
        S_RESYNC = 2'd2
    } ddsState_t;

    localparam logic [2:0] MODE_STOP = 3'd0;

    // Offset-binary zero for a sample of the given width
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/dds_wave_shaper.sv
// rtl/dds_wave_shaper.sv - registered phase-to-sample shaping stage with valid/wrap flags
module dds_wave_shaper
    import dds_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              Fg_CLK,
    input  logic              Fg_RESETn,
    input  logic              iFlush,
    input  logic              iValid,
    input  logic              iWrap,
    input  logic [DATA_W-1:0] iPhase,
    input  logic [1:0]        iWaveSel,
    output logic [DATA_W-1:0] oSample,
    output logic              oSampleValid,
    output logic              oCycleWrap
);

    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

    logic [DATA_W-1:0] ramp;
    logic [DATA_W-1:0] shaped;

    always_comb begin
        ramp   = {iPhase[DATA_W-2:0], 1'b0};
        shaped = MID;
        case (waveSel_t'(iWaveSel))
            WAVE_SAW:    shaped = iPhase;
            WAVE_SQUARE: shaped = iPhase[DATA_W-1] ? '0 : '1;
            WAVE_TRI:    shaped = iPhase[DATA_W-1] ? ~ramp : ramp;
            default:     shaped = MID;
        endcase
    end

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            oSample      <= MID;
            oSampleValid <= 1'b0;
            oCycleWrap   <= 1'b0;
        end else if (iFlush) begin
            oSample      <= MID;
            oSampleValid <= 1'b0;
            oCycleWrap   <= 1'b0;
        end else begin
            oSampleValid <= iValid;
            oCycleWrap   <= iValid & iWrap;
            if (iValid) begin
                oSample <= shaped;
            end
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - strobe-driven phase accumulator with run/resync control and tune shadowing
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int DATA_W  = 12
) (
    input  logic               Fg_CLK,
    input  logic               Fg_RESETn,
    input  logic               DDSEnable,
    input  logic               DDSReady,
    input  logic [2:0]         DDSMode,
    input  logic [PHASE_W-1:0] iTuneWord,
    input  logic               iTuneLoad,
    input  logic [1:0]         iWaveSel,
    output logic [DATA_W-1:0]  oSample,
    output logic               oSampleValid,
    output logic               oCycleWrap,
    output logic               oBusy
);

    ddsState_t          state;
    ddsState_t          nextState;
    logic               resyncCnt;
    logic [2:0]         modePrev;
    logic [PHASE_W-1:0] tuneShadow;
    logic [PHASE_W-1:0] tuneActive;
    logic [PHASE_W-1:0] phase;
    logic               phaseValid;
    logic               phaseWrap;
    logic [PHASE_W:0]   phaseSum;
    logic               stopReq;
    logic               flush;
    logic               accept;
    logic               carry;

    always_comb begin
        nextState = state;
        stopReq   = (DDSMode == MODE_STOP) || !DDSReady;
        case (state)
            S_WAIT:   if (!stopReq) nextState = S_RUN;
            S_RUN: begin
                if (stopReq)                    nextState = S_WAIT;
                else if (DDSMode != modePrev)   nextState = S_RESYNC;
            end
            S_RESYNC: begin
                if (stopReq)        nextState = S_WAIT;
                else if (resyncCnt) nextState = S_RUN;
            end
            default:  nextState = S_WAIT;
        endcase
    end

    // The cycle that leaves S_RUN already flushes, so a strobe or sample in flight never escapes
    assign flush    = (state != S_RUN) || (nextState != S_RUN);
    assign accept   = !flush && DDSEnable;
    assign phaseSum = {1'b0, phase} + {1'b0, tuneActive};
    assign carry    = phaseSum[PHASE_W];
    assign oBusy    = (state == S_RUN);

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            state     <= S_WAIT;
            resyncCnt <= 1'b0;
            modePrev  <= MODE_STOP;
        end else begin
            state     <= nextState;
            resyncCnt <= (state == S_RESYNC);
            modePrev  <= DDSMode;
        end
    end

    // A new word only takes effect at a cycle boundary or while the generator is idle
    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            tuneShadow <= '0;
            tuneActive <= '0;
        end else begin
            if (iTuneLoad) begin
                tuneShadow <= iTuneWord;
            end
            if (flush) begin
                tuneActive <= tuneShadow;
            end else if (accept && carry) begin
                tuneActive <= iTuneLoad ? iTuneWord : tuneShadow;
            end
        end
    end

    always_ff @(posedge Fg_CLK or negedge Fg_RESETn) begin
        if (!Fg_RESETn) begin
            phase      <= '0;
            phaseValid <= 1'b0;
            phaseWrap  <= 1'b0;
        end else if (flush) begin
            phase      <= '0;
            phaseValid <= 1'b0;
            phaseWrap  <= 1'b0;
        end else begin
            phaseValid <= accept;
            phaseWrap  <= accept & carry;
            if (accept) begin
                phase <= phaseSum[PHASE_W-1:0];
            end
        end
    end

    dds_wave_shaper #(
        .DATA_W(DATA_W)
    ) uShaper (
        .Fg_CLK      (Fg_CLK),
        .Fg_RESETn   (Fg_RESETn),
        .iFlush      (flush),
        .iValid      (phaseValid),
        .iWrap       (phaseWrap),
        .iPhase      (phase[PHASE_W-1 -: DATA_W]),
        .iWaveSel    (iWaveSel),
        .oSample     (oSample),
        .oSampleValid(oSampleValid),
        .oCycleWrap  (oCycleWrap)
    );

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb/tb_dds_phase_gen.sv - directed and randomized self-checking bench for dds_phase_gen
module tb_dds_phase_gen;

    localparam longint unsigned PMOD = 64'd16777216;

    logic        Fg_CLK    = 1'b0;
    logic        Fg_RESETn = 1'b0;
    logic        DDSEnable = 1'b0;
    logic        DDSReady  = 1'b0;
    logic [2:0]  DDSMode   = 3'd1;
    logic [23:0] iTuneWord = '0;
    logic        iTuneLoad = 1'b0;
    logic [1:0]  iWaveSel  = 2'd0;
    logic [11:0] oSample;
    logic        oSampleValid;
    logic        oCycleWrap;
    logic        oBusy;

    int errors = 0;
    int checks = 0;

    int unsigned mPhase  = 0;
    int unsigned mActive = 0;
    int unsigned mShadow = 0;
    int unsigned mSample = 2048;
    bit          p1V     = 0;
    bit          p1W     = 0;
    int unsigned p1Phase = 0;
    bit          coDone  = 0;

    dds_phase_gen #(.PHASE_W(24), .DATA_W(12)) dut (
        .Fg_CLK      (Fg_CLK),
        .Fg_RESETn   (Fg_RESETn),
        .DDSEnable   (DDSEnable),
        .DDSReady    (DDSReady),
        .DDSMode     (DDSMode),
        .iTuneWord   (iTuneWord),
        .iTuneLoad   (iTuneLoad),
        .iWaveSel    (iWaveSel),
        .oSample     (oSample),
        .oSampleValid(oSampleValid),
        .oCycleWrap  (oCycleWrap),
        .oBusy       (oBusy)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    function automatic int unsigned shape(input int unsigned ph, input int unsigned sel);
        int unsigned p;
        int unsigned t;
        p = ph / 4096;
        t = (p * 2) % 4096;
        case (sel)
            0:       return p;
            1:       return (p >= 2048) ? 0 : 4095;
            2:       return (p >= 2048) ? 4095 - t : t;
            default: return 2048;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // run=1 means the generator is in S_RUN this cycle and stays there
    task automatic cycle(input bit en, input bit run, input bit ld, input int unsigned word);
        bit              nV;
        bit              nW;
        int unsigned     nPh;
        longint unsigned sum;
        nV  = 0;
        nW  = 0;
        nPh = 0;
        DDSEnable = en;
        iTuneLoad = ld;
        iTuneWord = word[23:0];
        if (run) begin
            if (en) begin
                sum    = longint'(mPhase) + longint'(mActive);
                nW     = (sum >= PMOD);
                mPhase = int'(sum % PMOD);
                nV     = 1;
                nPh    = mPhase;
                if (nW) mActive = ld ? word : mShadow;
            end
        end else begin
            mPhase  = 0;
            mActive = mShadow;
        end
        if (ld) mShadow = word;
        @(posedge Fg_CLK);
        #1;
        if (!run) begin
            mSample = 2048;
            chk("valid_flushed", 32'(oSampleValid), 32'd0);
            chk("wrap_flushed", 32'(oCycleWrap), 32'd0);
        end else begin
            if (p1V) mSample = shape(p1Phase, 32'(iWaveSel));
            chk("valid", 32'(oSampleValid), 32'(p1V));
            chk("wrap", 32'(oCycleWrap), 32'(p1V & p1W));
        end
        chk("sample", 32'(oSample), mSample);
        p1V       = nV;
        p1W       = nW;
        p1Phase   = nPh;
        DDSEnable = 1'b0;
        iTuneLoad = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge Fg_CLK);
        #1;
        chk("rst_sample", 32'(oSample), 32'h800);
        chk("rst_valid", 32'(oSampleValid), 32'd0);
        chk("rst_wrap", 32'(oCycleWrap), 32'd0);
        chk("rst_busy", 32'(oBusy), 32'd0);
        @(negedge Fg_CLK);
        Fg_RESETn = 1'b1;

        // saw at 0x100000, strobe every cycle
        cycle(0, 0, 1, 32'h100000);
        cycle(0, 0, 0, 0);
        DDSReady = 1'b1;
        cycle(0, 0, 0, 0);
        chk("busy_run", 32'(oBusy), 32'd1);
        cycle(1, 1, 0, 0);
        chk("first_latency", 32'(oSampleValid), 32'd0);
        for (int i = 0; i < 18; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);

        // controller not ready
        DDSReady = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        chk("busy_notready", 32'(oBusy), 32'd0);
        DDSReady = 1'b1;
        cycle(1, 0, 0, 0);
        chk("busy_ready_again", 32'(oBusy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            iWaveSel = 2'($urandom_range(0, 3));
            cycle(1, 1, 0, 0);
        end

        // mode changes force resync
        DDSMode = 3'd2;
        cycle(1, 0, 0, 0);
        chk("busy_resync", 32'(oBusy), 32'd0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        iWaveSel = 2'd0;
        for (int i = 0; i < 6; i++) cycle(($urandom % 3) != 0 || i == 5, 1, 0, 0);
        DDSMode = 3'd3;
        cycle(1, 0, 0, 0);
        chk("resync_midscale", 32'(oSample), 32'h800);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);

        // shadowed tune loads, mid-cycle and coincident with a wrap
        for (int i = 0; i < 40; i++) begin
            bit          l;
            int unsigned w;
            l = 0;
            w = 0;
            if (i == 3) begin
                l = 1;
                w = 32'h200000;
            end else if (!coDone && mActive == 32'h200000 &&
                         (longint'(mPhase) + longint'(mActive)) >= PMOD) begin
                l = 1;
                w = 32'h300000;
                coDone = 1;
            end
            cycle(1, 1, l, w);
        end

        // randomized strobes, waveforms and loads
        for (int i = 0; i < 150; i++) begin
            iWaveSel = 2'($urandom_range(0, 3));
            cycle(($urandom % 4) != 0, 1, ($urandom % 16) == 0, $urandom % 32'h1000000);
        end

        // square and triangle at quarter-cycle steps
        DDSMode = 3'd4;
        cycle(0, 0, 1, 32'h400000);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        iWaveSel = 2'd1;
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);
        iWaveSel = 2'd2;
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);
        iWaveSel = 2'd3;
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);

        // zero tune word: samples keep coming, phase frozen
        DDSMode = 3'd1;
        iWaveSel = 2'd0;
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);

        // asynchronous reset with a sample in flight
        DDSMode = 3'd4;
        cycle(0, 0, 1, 32'h123456);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        #1;
        Fg_RESETn = 1'b0;
        #1;
        chk("async_sample", 32'(oSample), 32'h800);
        chk("async_valid", 32'(oSampleValid), 32'd0);
        chk("async_wrap", 32'(oCycleWrap), 32'd0);
        chk("async_busy", 32'(oBusy), 32'd0);
        mPhase  = 0;
        mActive = 0;
        mShadow = 0;
        mSample = 2048;
        p1V     = 0;
        p1W     = 0;
        @(posedge Fg_CLK);
        @(negedge Fg_CLK);
        Fg_RESETn = 1'b1;
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
